// File: rtl/prga_prog_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prga_prog_receiver                                           |
// | Description : Serial bitstream receiver. Hunts for a sync word, unpacks a  |
// |               length-prefixed frame into configuration words behind a      |
// |               2-entry ready/valid FIFO, then forwards later serial traffic |
// |               down the daisy chain. Optional CRC-16 trailer check when     |
// |               PRGA_PROG_CRC_EN is defined.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prga_prog_receiver #(
   parameter int          WORD_WIDTH = 8,
   parameter logic [15:0] SYNC_WORD  = 16'hA55A
) (
   input  logic                  prog_clk,
   input  logic                  prog_rst_n,
   input  logic                  prog_we,
   input  logic                  prog_din,
   output logic [WORD_WIDTH-1:0] cfg_data,
   output logic                  cfg_valid,
   input  logic                  cfg_ready,
   output logic                  prog_done,
   output logic                  prog_err,
   output logic                  prog_dout,
   output logic                  prog_we_o
);

   localparam int              c_bcw      = $clog2(WORD_WIDTH);
   localparam logic [c_bcw-1:0] c_bit_last = c_bcw'(WORD_WIDTH - 1);

   typedef enum logic [2:0] {
      S_SYNC = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
      S_CRC  = 3'd3,
      S_FIN  = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   state_t                r_state;
   logic [14:0]           r_shift;
   logic [3:0]            r_fld_cnt;
   logic [c_bcw-1:0]      r_bit_cnt;
   logic [WORD_WIDTH-2:0] r_word_sr;
   logic [15:0]           r_word_cnt;

   logic [WORD_WIDTH-1:0] r_mem [2];
   logic                  r_rd_ptr;
   logic                  r_wr_ptr;
   logic [1:0]            r_count;

   logic [15:0]           w_shift_next;
   logic [WORD_WIDTH-1:0] w_word_next;
   logic                  w_fld_last;
   logic                  w_word_last;
   logic                  w_len_zero;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_overflow;
   logic                  w_crc_bad;
   logic                  w_err_set;
   logic                  w_fin_entry;
   logic                  w_done_set;
   logic [1:0]            w_count_next;

   // Full 16-bit views are formed from the stored 15/WORD_WIDTH-1 bits plus the incoming bit
   assign w_shift_next = {r_shift, prog_din};
   assign w_word_next  = {r_word_sr, prog_din};
   assign w_fld_last   = (r_fld_cnt == 4'hF);
   assign w_word_last  = (r_bit_cnt == c_bit_last);
   assign w_len_zero   = (w_shift_next == 16'h0000);

   assign cfg_valid  = (r_count != 2'd0);
   assign cfg_data   = r_mem[r_rd_ptr];
   assign w_push     = (r_state == S_DATA) && prog_we && w_word_last;
   assign w_pop      = cfg_valid && cfg_ready;
   assign w_overflow = w_push && (r_count == 2'd2) && !w_pop;
   assign w_err_set  = w_overflow || w_crc_bad;

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop)
         w_count_next = r_count + 2'd1;
      else if (!w_push && w_pop)
         w_count_next = r_count - 2'd1;
   end

`ifdef PRGA_PROG_CRC_EN
   logic [15:0] r_crc;
   logic [15:0] w_crc_next;
   logic        w_crc_fb;

   // CRC-16-CCITT, one bit per qualified cycle, MSB first
   assign w_crc_fb    = r_crc[15] ^ prog_din;
   assign w_crc_next  = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);
   assign w_crc_bad   = (r_state == S_CRC) && prog_we && w_fld_last && (w_shift_next != r_crc);
   assign w_fin_entry = (r_state == S_CRC) && prog_we && w_fld_last && (w_shift_next == r_crc);
`else
   assign w_crc_bad   = 1'b0;
   assign w_fin_entry = prog_we &&
                        (((r_state == S_LEN) && w_fld_last && w_len_zero) ||
                         (w_push && (r_word_cnt == 16'd1)));
`endif

   // Done may assert on the very edge that enters FIN when nothing is left to drain
   assign w_done_set = (w_fin_entry || (r_state == S_FIN)) && (w_count_next == 2'd0);

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         r_state    <= S_SYNC;
         r_shift    <= '0;
         r_fld_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_word_sr  <= '0;
         r_word_cnt <= '0;
         prog_done  <= 1'b0;
         prog_err   <= 1'b0;
         prog_dout  <= 1'b0;
         prog_we_o  <= 1'b0;
`ifdef PRGA_PROG_CRC_EN
         r_crc      <= 16'hFFFF;
`endif
      end else begin
         prog_dout <= prog_done & prog_din;
         prog_we_o <= prog_done & prog_we;
         if (w_done_set)
            prog_done <= 1'b1;

         case (r_state)
            S_SYNC: begin
               if (prog_we) begin
                  r_shift <= w_shift_next[14:0];
                  if (w_shift_next == SYNC_WORD) begin
                     r_state   <= S_LEN;
                     r_fld_cnt <= '0;
`ifdef PRGA_PROG_CRC_EN
                     r_crc     <= 16'hFFFF;
`endif
                  end
               end
            end

            S_LEN: begin
               if (prog_we) begin
                  r_shift   <= w_shift_next[14:0];
                  r_fld_cnt <= r_fld_cnt + 4'd1;
`ifdef PRGA_PROG_CRC_EN
                  r_crc     <= w_crc_next;
`endif
                  if (w_fld_last) begin
                     r_word_cnt <= w_shift_next;
                     r_bit_cnt  <= '0;
                     r_fld_cnt  <= '0;
                     if (!w_len_zero)
                        r_state <= S_DATA;
`ifdef PRGA_PROG_CRC_EN
                     else
                        r_state <= S_CRC;
`else
                     else
                        r_state <= S_FIN;
`endif
                  end
               end
            end

            S_DATA: begin
               if (prog_we) begin
                  r_word_sr <= w_word_next[WORD_WIDTH-2:0];
`ifdef PRGA_PROG_CRC_EN
                  r_crc     <= w_crc_next;
`endif
                  if (w_word_last) begin
                     r_bit_cnt  <= '0;
                     r_word_cnt <= r_word_cnt - 16'd1;
                     if (r_word_cnt == 16'd1) begin
                        r_fld_cnt <= '0;
`ifdef PRGA_PROG_CRC_EN
                        r_state   <= S_CRC;
`else
                        r_state   <= S_FIN;
`endif
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
            end

            S_CRC: begin
`ifdef PRGA_PROG_CRC_EN
               if (prog_we) begin
                  r_shift   <= w_shift_next[14:0];
                  r_fld_cnt <= r_fld_cnt + 4'd1;
                  if (w_fin_entry)
                     r_state <= S_FIN;
               end
`else
               r_state <= S_FIN;
`endif
            end

            S_FIN:   r_state <= S_FIN;
            S_ERR:   r_state <= S_ERR;
            default: r_state <= S_SYNC;
         endcase

         // Overflow and CRC mismatch override any transition taken above
         if (w_err_set) begin
            r_state  <= S_ERR;
            prog_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (w_err_set) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push)
            r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         r_count <= w_count_next;
      end
   end

   // When full, a simultaneous push lands in the slot being popped this cycle
   always_ff @(posedge prog_clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= w_word_next;
   end

endmodule
`default_nettype wire

// File: tb/tb_prga_prog_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_prga_prog_receiver                                        |
// | Description : Directed bench for prga_prog_receiver with a word scoreboard.|
// |               Sends CRC trailers when PRGA_PROG_CRC_EN is defined.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_prga_prog_receiver;
   localparam int WW = 8;

   logic          prog_clk   = 1'b0;
   logic          prog_rst_n = 1'b0;
   logic          prog_we    = 1'b0;
   logic          prog_din   = 1'b0;
   logic          cfg_ready  = 1'b1;
   logic [WW-1:0] cfg_data;
   logic          cfg_valid;
   logic          prog_done;
   logic          prog_err;
   logic          prog_dout;
   logic          prog_we_o;

   int            tests    = 0;
   int            fails    = 0;
   int            rdy_mode = 0;
   int            cyc      = 0;
   logic [WW-1:0] exp_q [$];
   logic [WW-1:0] frame_words [8];
   logic [WW-1:0] mon_exp;
`ifdef PRGA_PROG_CRC_EN
   logic          crc_flip = 1'b0;
`endif

   prga_prog_receiver #(.WORD_WIDTH(WW), .SYNC_WORD(16'hA55A)) dut (
      .prog_clk   (prog_clk),
      .prog_rst_n (prog_rst_n),
      .prog_we    (prog_we),
      .prog_din   (prog_din),
      .cfg_data   (cfg_data),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .prog_done  (prog_done),
      .prog_err   (prog_err),
      .prog_dout  (prog_dout),
      .prog_we_o  (prog_we_o)
   );

   always #5 prog_clk = ~prog_clk;

   // Consumer: 0 = always ready, 1 = never ready, 2 = ready one cycle in four
   always begin
      @(posedge prog_clk);
      #1;
      cyc++;
      case (rdy_mode)
         1:       cfg_ready = 1'b0;
         2:       cfg_ready = ((cyc % 4) == 0);
         default: cfg_ready = 1'b1;
      endcase
   end

   always @(negedge prog_clk) begin
      if (cfg_valid && cfg_ready) begin
         tests++;
         assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_word: observed %h, expected no word", cfg_data);
         end
         if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            tests++;
            assert (cfg_data === mon_exp) else begin
               fails++;
               $error("FAIL cfg_data: observed %h expected %h", cfg_data, mon_exp);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n, input bit gaps);
      for (int i = n - 1; i >= 0; i--) begin
         if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) begin
               tick();
               prog_we  = 1'b0;
               prog_din = 1'($urandom_range(0, 1));
            end
         end
         tick();
         prog_we  = 1'b1;
         prog_din = v[i];
      end
   endtask

   task automatic idle();
      tick();
      prog_we  = 1'b0;
      prog_din = 1'b0;
   endtask

   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [31:0] v, input int n);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = n - 1; i >= 0; i--) begin
         fb = r[15] ^ v[i];
         r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return r;
   endfunction

   task automatic send_frame(input int n, input bit gaps, input bit expect_words);
`ifdef PRGA_PROG_CRC_EN
      logic [15:0] crc;
      crc = 16'hFFFF;
      crc = crc_upd(crc, 32'(n), 16);
      for (int i = 0; i < n; i++)
         crc = crc_upd(crc, 32'(frame_words[i]), WW);
`endif
      send_bits(32'h0000_A55A, 16, gaps);
      send_bits(32'(n), 16, gaps);
      for (int i = 0; i < n; i++) begin
         if (expect_words)
            exp_q.push_back(frame_words[i]);
         send_bits(32'(frame_words[i]), WW, gaps);
      end
`ifdef PRGA_PROG_CRC_EN
      send_bits(32'(crc ^ {15'd0, crc_flip}), 16, gaps);
`endif
      idle();
   endtask

   task automatic do_reset(input string tag);
      tick();
      prog_rst_n = 1'b0;
      prog_we    = 1'b0;
      prog_din   = 1'b0;
      repeat (2) tick();
      check(tag, {27'd0, cfg_valid, prog_done, prog_err, prog_dout, prog_we_o}, 32'd0);
      prog_rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_done(input int max, input string tag);
      int k;
      k = 0;
      while (!prog_done && k < max) begin
         @(negedge prog_clk);
         k++;
      end
      check(tag, 32'(prog_done), 32'd1);
   endtask

   task automatic check_no_forward(input string tag);
      for (int i = 0; i < 4; i++) begin
         tick();
         prog_we  = 1'b1;
         prog_din = 1'b1;
      end
      @(negedge prog_clk);
      check(tag, {30'd0, prog_we_o, prog_dout}, 32'd0);
      idle();
   endtask

   initial begin
      logic we_pat  [3];
      logic din_pat [3];

      // Power-on reset
      repeat (3) tick();
      check("reset_outputs", {27'd0, cfg_valid, prog_done, prog_err, prog_dout, prog_we_o}, 32'd0);
      prog_rst_n = 1'b1;
      tick();

      // Basic two-word frame with leading garbage
      send_bits(32'h0000_00FF, 8, 1'b0);
      frame_words[0] = 8'h3C;
      frame_words[1] = 8'hC3;
      send_frame(2, 1'b0, 1'b1);
      @(negedge prog_clk);
`ifdef PRGA_PROG_CRC_EN
      check("done_after_trailer", 32'(prog_done), 32'd1);
`else
      check("valid_after_last_bit", 32'(cfg_valid), 32'd1);
      check("done_not_early", 32'(prog_done), 32'd0);
      @(negedge prog_clk);
      check("done_after_drain", 32'(prog_done), 32'd1);
`endif
      check("basic_err", 32'(prog_err), 32'd0);
      check("basic_queue_empty", 32'(exp_q.size()), 32'd0);

      // Daisy-chain forwarding, one cycle latency
      we_pat[0]  = 1'b1; din_pat[0] = 1'b1;
      we_pat[1]  = 1'b0; din_pat[1] = 1'($urandom_range(0, 1));
      we_pat[2]  = 1'b1; din_pat[2] = 1'b0;
      tick();
      prog_we  = we_pat[0];
      prog_din = din_pat[0];
      for (int i = 0; i < 3; i++) begin
         tick();
         check("fwd_we", 32'(prog_we_o), 32'(we_pat[i]));
         check("fwd_dout", 32'(prog_dout), 32'(din_pat[i]));
         if (i < 2) begin
            prog_we  = we_pat[i+1];
            prog_din = din_pat[i+1];
         end
      end
      prog_we  = 1'b0;
      prog_din = 1'b0;

      // Empty frame
      do_reset("reset_before_n0");
      send_frame(0, 1'b0, 1'b0);
      @(negedge prog_clk);
      check("n0_done", 32'(prog_done), 32'd1);
      check("n0_err", 32'(prog_err), 32'd0);

`ifdef PRGA_PROG_CRC_EN
      // Corrupted trailer
      do_reset("reset_before_badcrc");
      frame_words[0] = 8'h3C;
      frame_words[1] = 8'hC3;
      crc_flip = 1'b1;
      send_frame(2, 1'b0, 1'b1);
      crc_flip = 1'b0;
      @(negedge prog_clk);
      check("badcrc_err", 32'(prog_err), 32'd1);
      check("badcrc_done", 32'(prog_done), 32'd0);
      check("badcrc_valid", 32'(cfg_valid), 32'd0);
      check_no_forward("badcrc_no_forward");
`endif

      // Overflow: consumer stalled for a three-word frame
      do_reset("reset_before_ovf");
      rdy_mode = 1;
      frame_words[0] = 8'h12;
      frame_words[1] = 8'h34;
      frame_words[2] = 8'h56;
      send_frame(3, 1'b0, 1'b0);
      @(negedge prog_clk);
      check("ovf_err", 32'(prog_err), 32'd1);
      check("ovf_valid_flushed", 32'(cfg_valid), 32'd0);
      check("ovf_done", 32'(prog_done), 32'd0);
      check_no_forward("ovf_no_forward");
      rdy_mode = 0;

      // Sparse consumer with gaps in the bit stream
      do_reset("reset_before_gaps");
      rdy_mode = 2;
      frame_words[0] = 8'hA1;
      frame_words[1] = 8'h5E;
      frame_words[2] = 8'h00;
      frame_words[3] = 8'hFF;
      send_frame(4, 1'b1, 1'b1);
      wait_done(300, "gaps_done");
      check("gaps_err", 32'(prog_err), 32'd0);
      check("gaps_queue_empty", 32'(exp_q.size()), 32'd0);
      rdy_mode = 0;

      // Reset in the middle of a data word, then a clean frame
      do_reset("reset_before_abort");
      send_bits(32'h0000_A55A, 16, 1'b0);
      send_bits(32'd3, 16, 1'b0);
      send_bits(32'hA, 4, 1'b0);
      do_reset("reset_mid_data");
      frame_words[0] = 8'h11;
      frame_words[1] = 8'h22;
      send_frame(2, 1'b0, 1'b1);
      wait_done(50, "abort_done");
      check("abort_err", 32'(prog_err), 32'd0);
      check("abort_queue_empty", 32'(exp_q.size()), 32'd0);

      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/prga_prog_receiver.md
# prga_prog_receiver

Fabric-side receiving end of the serial bitstream programming interface (prog_clk / prog_we / prog_din). Hunts for a sync word, parses a length-prefixed frame of configuration words, and presents each word on a ready/valid port to the configuration chain writer. Signals completion or error, then forwards all later serial traffic to the next device in the daisy chain via prog_dout / prog_we_o.

## Interface
- WORD_WIDTH, 8: payload word width in bits (4..32).
- SYNC_WORD, 16'hA55A: 16-bit frame start pattern.
- prog_clk  in  1  programming clock; all logic on rising edge.
- prog_rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  serial bit qualifier; prog_din is sampled only when high.
- prog_din  in  1  serial data, MSB first.
- cfg_data  out  WORD_WIDTH  configuration word.
- cfg_valid  out  1  cfg_data valid.
- cfg_ready  in  1  consumer accepts when cfg_valid && cfg_ready.
- prog_done  out  1  frame accepted and all words drained; sticky.
- prog_err  out  1  CRC mismatch or overflow; sticky.
- prog_dout  out  1  daisy-chain forwarded data.
- prog_we_o  out  1  daisy-chain forwarded qualifier.

## Operation
- One clock (prog_clk); reset asynchronous, active-low (prog_rst_n). All outputs 0 during and after reset; state SYNC.
- A "bit" is one cycle with prog_we=1. Cycles with prog_we=0 change no parsing state (gaps allowed anywhere).
- SYNC: 16-bit shift register of received bits (cleared at reset); when its value after a shift equals SYNC_WORD -> LEN. Leading garbage is tolerated.
- LEN: next 16 bits, MSB first, form N (word count). On 16th bit: N=0 -> CRC (or FIN if CRC disabled); else -> DATA.
- DATA: every WORD_WIDTH bits form one word, pushed into a 2-entry FIFO on the cycle after its last bit. After the N-th word -> CRC / FIN.
- CRC (macro-gated): next 16 bits compared with computed CRC; equal -> FIN, else -> ERR.
- FIN: prog_done=1 once FIFO empty and stays 1 until reset. Words already in FIFO still drain.
- ERR: prog_err=1 sticky; FIFO flushed, cfg_valid=0; all further bits ignored (no forwarding) until reset.
- Overflow: push while FIFO holds 2 and no pop that same cycle -> ERR. Push and pop in same cycle with FIFO full is legal.
- Forwarding: only once prog_done=1; each cycle prog_dout<=prog_din, prog_we_o<=prog_we (registered). Otherwise both 0.
- Word counter 16-bit; bit counter ceil(log2(WORD_WIDTH)) bits, wraps to 0 at each word boundary.

## Timing
- cfg_valid rises the cycle after the last bit of a word is sampled; cfg_data stable while cfg_valid && !cfg_ready.
- FIFO pop and push are independent; FIFO order preserved, first-word fall-through.
- prog_done rises earliest the cycle after FIN entry with FIFO empty (last trailer bit +1 cycle when N=0).
- prog_err rises the cycle after the offending bit / push.
- Forwarding latency: 1 cycle.
- Reset mid-frame: immediately returns to SYNC, FIFO emptied, counters and CRC cleared.

## Configuration
- PRGA_PROG_CRC_EN defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR), bit-serial over all LEN and payload bits; 16-bit trailer checked in state CRC.
- Undefined: no CRC logic, no trailer; LEN/DATA completion goes directly to FIN; prog_err only from overflow.

## Test plan
- Macro off, WORD_WIDTH=8: bits 0xFF, 0xA55A, 0x0002, 0x3C, 0xC3, cfg_ready=1 -> cfg_data 0x3C then 0xC3, prog_done=1 one cycle after FIFO drains, prog_err=0.
- Macro on: same frame with correct CRC trailer -> prog_done=1; trailer with one bit flipped -> prog_err=1, prog_done=0, no forwarding.
- Backpressure: cfg_ready=0 during 3-word frame of continuous bits -> third push overflows, prog_err=1; with cfg_ready toggling 1-of-4 cycles and prog_we gaps -> all words delivered in order.
- N=0: 0xA55A, 0x0000 (+CRC when on) -> no cfg_valid, prog_done=1.
- Daisy chain: after prog_done, drive prog_we/prog_din pattern 1/1,0/x,1/0 -> same on prog_we_o/prog_dout one cycle later.
- Reset pulse mid-DATA, then full valid frame -> only second frame's words emitted, prog_done=1.
